// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester (master) and the register-bank completer.
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed register bank with programmable wait states,
// range/alignment error responses, sticky protocol-violation flag and a
// saturating error-response counter.
module apb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           WAIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_slave_mem_if.slave        apb,
  input  logic [WAIT_WIDTH-1:0] wait_cfg,
  output logic                  prot_err,
  output logic [7:0]            err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WAIT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    prot_err_q, prot_err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  // An address below BASE_ADDR borrows into the extra top bit, so a single
  // unsigned compare against the window size covers both range limits.
  logic [ADDR_WIDTH:0]     offset;
  logic                    addr_err;

  assign offset   = {1'b0, apb.paddr} - {1'b0, BASE_ADDR};
  assign addr_err = (offset >= SPAN) || (apb.paddr[1:0] != 2'b00);

  // Transfer sequencing, latching, memory update and status next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    prot_err_d = prot_err_q;
    err_cnt_d  = err_cnt_q;
    mem_d      = mem_q;

    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          // BASE_ADDR is aligned to the window size, so the word index can be
          // taken directly from the address bits.
          idx_d   = apb.paddr[IDX_W+1:2];
          err_d   = addr_err;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          cnt_d   = wait_cfg;
          state_d = (wait_cfg != '0) ? WAIT : DONE;
        end else if (apb.psel && apb.penable) begin
          prot_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          prot_err_d = 1'b1;
          state_d    = IDLE;
        end else if (apb.penable) begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
          if (cnt_q == WAIT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (err_q) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (write_q) begin
          mem_d[idx_q] = wdata_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is captured on entry to DONE so it is stable for the whole
    // completion cycle; writes leave the previous read value in place.
    if (state_d == DONE && state_q != DONE) begin
      if (err_d) begin
        prdata_d = '0;
      end else if (!write_d) begin
        prdata_d = mem_q[idx_d];
      end
    end
  end

  // State, latched transfer attributes, status and memory registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
      err_cnt_q  <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
      err_cnt_q  <= err_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = (state_q == DONE);
  assign apb.pslverr = (state_q == DONE) && err_q;
  assign prot_err    = prot_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem against a transaction-level model.
module tb_apb_slave_mem;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wait_cfg;
  logic       prot_err;
  logic [7:0] err_cnt;

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_slave_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .apb(bus.slave),
    .wait_cfg(wait_cfg),
    .prot_err(prot_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Transaction-level model state
  logic [31:0] mmem [DEPTH];
  logic        exp_pready, exp_pslverr, exp_prot, exp_rd;
  logic [31:0] exp_prdata;
  int          exp_errcnt;
  logic        pend, p_err, p_w;
  int          p_idx;
  logic [31:0] p_data;
  int          lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic addr_err(input logic [31:0] a);
    longint unsigned ua, lo, hi;
    ua = a;
    lo = BASE;
    hi = lo + DEPTH * 4;
    return (ua < lo) || (ua >= hi) || (a[1:0] != 2'b00);
  endfunction

  task automatic model_reset();
    foreach (mmem[i]) mmem[i] = '0;
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prot    = 1'b0;
    exp_rd      = 1'b0;
    exp_prdata  = '0;
    exp_errcnt  = 0;
    pend        = 1'b0;
  endtask

  // Advance one cycle; a completed transfer's side effects become visible now.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend) begin
      if (p_err) exp_errcnt = (exp_errcnt == 255) ? 255 : exp_errcnt + 1;
      else if (p_w) mmem[p_idx] = p_data;
      pend = 1'b0;
    end
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_rd      = 1'b0;
  endtask

  task automatic idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    tick();
  endtask

  // One APB transfer with n wait states; abort_after>0 drops psel after that
  // many ACCESS cycles. lat records the ACCESS cycle in which pready was seen.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int n, input int abort_after);
    logic e;
    int   idx;
    e   = addr_err(a);
    idx = e ? 0 : int'((a - BASE) >> 2);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = a;
    bus.pwdata  = d;
    wait_cfg    = 4'(n);
    tick();
    bus.penable = 1'b1;
    bus.paddr   = $urandom;
    bus.pwdata  = $urandom;
    wait_cfg    = 4'($urandom);
    lat = 0;
    for (int k = 1; k <= n; k++) begin
      if (bus.pready && lat == 0) lat = k;
      if (abort_after > 0 && k == abort_after + 1) begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        tick();
        exp_prot = 1'b1;
        return;
      end
      tick();
    end
    if (bus.pready && lat == 0) lat = n + 1;
    exp_pready  = 1'b1;
    exp_pslverr = e;
    exp_rd      = !w;
    if (e) exp_prdata = '0;
    else if (!w) exp_prdata = mmem[idx];
    pend   = 1'b1;
    p_err  = e;
    p_w    = w;
    p_idx  = idx;
    p_data = d;
    tick();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("pready", 32'(bus.pready), 32'(exp_pready));
    chk("pslverr", 32'(bus.pslverr), 32'(exp_pslverr));
    chk("prot_err", 32'(prot_err), 32'(exp_prot));
    chk("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
    if (exp_pready && exp_rd) chk("prdata", bus.prdata, exp_prdata);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r, n, ab;
    logic        w;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;    wait_cfg = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_prdata", bus.prdata, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_prot_err", 32'(prot_err), 32'h0);

    // Write then read back with no wait states
    xfer(1'b1, 32'h08, 32'hDEADBEEF, 0, 0);
    chk("wr_latency0", 32'(lat), 32'd1);
    xfer(1'b0, 32'h08, 32'h0, 0, 0);
    chk("rd_latency0", 32'(lat), 32'd1);
    chk("rd_08", bus.prdata, 32'hDEADBEEF);

    // Read with three wait states
    idle();
    xfer(1'b0, 32'h04, 32'h0, 3, 0);
    chk("rd_latency3", 32'(lat), 32'd4);
    chk("rd_04", bus.prdata, 32'h0);

    // Out-of-range and misaligned writes
    xfer(1'b1, 32'h40, 32'h12345678, 0, 0);
    xfer(1'b1, 32'h06, 32'h12345678, 1, 0);
    idle();
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
    xfer(1'b0, 32'h00, 32'h0, 0, 0);
    chk("rd_00_clean", bus.prdata, 32'h0);
    xfer(1'b0, 32'h04, 32'h0, 0, 0);
    chk("rd_04_clean", bus.prdata, 32'h0);

    // Protocol violations: ACCESS without SETUP, then abort during waits
    bus.psel = 1'b1; bus.penable = 1'b1;
    tick();
    exp_prot = 1'b1;
    chk("prot_noset", 32'(prot_err), 32'd1);
    idle();
    xfer(1'b1, 32'h10, 32'hCAFEF00D, 5, 2);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 0, 0);
    chk("rd_10_aborted", bus.prdata, 32'h0);
    xfer(1'b0, 32'h00, 32'h0, 0, 0);
    chk("rd_00_after_abort", bus.prdata, 32'h0);

    // Reset in the middle of a waited write
    xfer(1'b1, 32'h0C, 32'hA5A5A5A5, 0, 0);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h0C; bus.pwdata = 32'h0000FFFF; wait_cfg = 4'd4;
    tick();
    bus.penable = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_pready", 32'(bus.pready), 32'h0);
    chk("arst_pslverr", 32'(bus.pslverr), 32'h0);
    chk("arst_prdata", bus.prdata, 32'h0);
    chk("arst_prot_err", 32'(prot_err), 32'h0);
    chk("arst_err_cnt", 32'(err_cnt), 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    xfer(1'b0, 32'h0C, 32'h0, 0, 0);
    chk("rd_0C_after_rst", bus.prdata, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 8) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else             a = BASE + DEPTH * 4 + 32'($urandom_range(0, 1000)) * 4;
      w  = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 4);
      ab = 0;
      if (n > 1 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, n - 1);
      if ($urandom_range(0, 2) == 0) idle();
      xfer(w, a, $urandom, n, ab);
    end

    // Error counter saturation
    idle();
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, 32'h100 + 32'(i) * 4, 32'h0, 0, 0);
    end
    idle();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (responder) at the far end of the bridge's APB master port.
- Contains a word-addressed register array, a per-transfer wait-state counter and range/alignment error detection.
- Used as the APB target in bridge-level simulation and as a small on-chip peripheral register bank.
- Accepts SETUP/ACCESS transfers, inserts programmable wait states, then completes with PREADY, optionally with PSLVERR.

Parameters:
- ADDR_WIDTH, 32, width of paddr
- DATA_WIDTH, 32, width of pwdata/prdata; must be 32
- DEPTH, 16, number of 32-bit words; power of two, 2..256
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4 aligned
- WAIT_WIDTH, 4, width of wait_cfg

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- psel  input  1  APB select
- penable  input  1  APB enable (ACCESS phase)
- pwrite  input  1  1 = write, 0 = read
- paddr  input  ADDR_WIDTH  byte address
- pwdata  input  DATA_WIDTH  write data
- wait_cfg  input  WAIT_WIDTH  wait states for the next transfer, sampled in SETUP
- prdata  output  DATA_WIDTH  read data, valid while pready=1 on a read
- pready  output  1  transfer completion
- pslverr  output  1  error response, valid only while pready=1
- prot_err  output  1  sticky protocol-violation flag
- err_cnt  output  8  count of PSLVERR responses, saturating at 255

Behaviour:
- Reset (async, rst=1): prdata=0, pready=0, pslverr=0, prot_err=0, err_cnt=0, all memory words=0, state=IDLE. Reset mid-transfer aborts the transfer and any pending write is discarded.
- States: IDLE, WAIT, DONE.
- IDLE:
  - psel=1 && penable=0 (SETUP) latches paddr, pwrite, pwdata and wait_cfg into the counter.
  - Computes err = (paddr < BASE_ADDR) || (paddr >= BASE_ADDR+DEPTH*4) || (paddr[1:0] != 0).
  - Next state is WAIT if wait_cfg > 0, else DONE.
  - psel=1 && penable=1 seen in IDLE is a violation: set prot_err, stay in IDLE, pready stays 0.
- WAIT:
  - Each cycle with psel=1 && penable=1, decrement the counter. At counter==1 → DONE.
  - psel=0 in WAIT is an abort: set prot_err, go to IDLE, no write.
- DONE:
  - pready=1 combinationally, with pslverr=err, for exactly one cycle. The master must hold psel/penable=1.
  - Latency: pready is high in the first ACCESS cycle when wait_cfg=0, or after N extra ACCESS cycles when wait_cfg=N.
  - Write with err=0: mem[index] <= latched pwdata on the DONE clock edge, where index = (paddr-BASE_ADDR)>>2.
  - Read with err=0: prdata = mem[index], registered on entry to DONE.
  - err=1: no memory update and prdata=0.
  - Next state is IDLE. Back-to-back transfers are allowed: a SETUP in the cycle after DONE is accepted normally.
- Read-after-write to the same address in consecutive transfers returns the new data.
- err_cnt increments in each DONE cycle with err=1 and holds at 255.
- prdata holds its last value outside DONE; pslverr=0 whenever pready=0.
- pwdata, paddr and wait_cfg changes after SETUP are ignored (latched values are used).
- prot_err clears only on reset.

Test Plan:
- Write 0xDEADBEEF to 0x08 with wait_cfg=0, then read 0x08 with wait_cfg=0 → write pready in its first ACCESS cycle; read prdata=0xDEADBEEF, pslverr=0.
- Read 0x04 with wait_cfg=3 → pready=0 for 3 ACCESS cycles, pready=1 on the 4th ACCESS cycle, prdata=0 (reset contents).
- Write 0x12345678 to 0x40 (out of range, DEPTH=16), then write to 0x06 (misaligned) → both complete with pslverr=1; err_cnt=2; all memory words unchanged (readback 0).
- penable=1 without a SETUP, then a separate transfer with wait_cfg=5 where psel drops after 2 ACCESS cycles → prot_err=1; no write occurs; the next normal read of 0x00 returns 0 with pslverr=0.
- Write 0xA5A5A5A5 to 0x0C, then write 0x0000FFFF to 0x0C with wait_cfg=4 and assert rst on the 2nd wait cycle → all outputs 0 asynchronously; readback of 0x0C = 0.
- Generate 260 out-of-range reads → err_cnt saturates at 255; pslverr=1 on each.
